frame_window_buffer: RTL and testbench

FRAME_WINDOW_BUFFER -- requirements
Module: frame_window_buffer

---
 rtl/frame_window_buffer.sv | 219 +++++++++++++++++++++
 tb/tb_frame_window_buffer.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_window_buffer.sv
// rtl/frame_window_buffer.sv - banked frame store streaming KERNEL_WIDTH-row vertical slices
// Define FRAME_WINDOW_ZERO_PAD_EN to slide the window off the top/bottom edge with zero lanes.
module frame_window_buffer #(
  parameter int RAM_WIDTH    = 8,
  parameter int IMAGE_WIDTH  = 10,
  parameter int IMAGE_HEIGHT = 10,
  parameter int KERNEL_WIDTH = 3
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              i_load_valid,
  input  logic [RAM_WIDTH-1:0]              i_data_to_mem,
  output logic                              o_load_ready,
  input  logic                              i_read_valid,
  output logic                              o_frame_ready,
  output logic                              o_valid_data_to_conv,
  input  logic                              i_conv_ready,
  output logic [KERNEL_WIDTH*RAM_WIDTH-1:0] o_to_conv,
  output logic                              o_frame_done
);

  localparam int CW        = (IMAGE_WIDTH > 1) ? $clog2(IMAGE_WIDTH) : 1;
  localparam int RW        = (IMAGE_HEIGHT > 1) ? $clog2(IMAGE_HEIGHT) : 1;
  localparam int KW        = (KERNEL_WIDTH > 1) ? $clog2(KERNEL_WIDTH) : 1;
  localparam int KW1       = KW + 1;
  localparam int DW        = RW + 1;
  localparam int BANK_ROWS = (IMAGE_HEIGHT + KERNEL_WIDTH - 1) / KERNEL_WIDTH;
  localparam int DEPTH     = BANK_ROWS * IMAGE_WIDTH;
  localparam int AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
`ifdef FRAME_WINDOW_ZERO_PAD_EN
  localparam int PAD       = (KERNEL_WIDTH - 1) / 2;
  localparam int NUM_TOPS  = IMAGE_HEIGHT;
`else
  localparam int PAD       = 0;
  localparam int NUM_TOPS  = IMAGE_HEIGHT - KERNEL_WIDTH + 1;
`endif
  // Top row is tracked as u = top + KERNEL_WIDTH so it never goes negative.
  localparam int U0        = KERNEL_WIDTH - PAD;
  localparam int TMOD0     = U0 % KERNEL_WIDTH;
  localparam int TDIV0     = U0 / KERNEL_WIDTH;

  typedef enum logic [1:0] {LOAD, FULL, STREAM} state_t;
  state_t state, state_next;

  logic [CW-1:0]  wr_col;
  logic [RW-1:0]  wr_row;
  logic [KW-1:0]  wr_bank;
  logic [RW-1:0]  wr_brow;
  logic [AW-1:0]  wr_addr;
  logic           wr_en, last_pix;

  logic [CW-1:0]  rd_col;
  logic [RW-1:0]  rd_step;
  logic [KW-1:0]  top_mod;
  logic [DW-1:0]  top_div;
  logic           issue_done, issue;
  logic [AW-1:0]  rd_addr [KERNEL_WIDTH];
  logic [KERNEL_WIDTH-1:0] bank_ok, lane_ok_q;
  logic [KW-1:0]  tmod_q;

  logic [RAM_WIDTH-1:0] mem    [KERNEL_WIDTH][DEPTH];
  logic [RAM_WIDTH-1:0] bank_q [KERNEL_WIDTH];

  logic                              rd_valid, skid_valid, frame_done_q;
  logic [KERNEL_WIDTH*RAM_WIDTH-1:0] rot_data, skid_data;
  logic                              hs, last_hs;

  assign wr_en    = i_load_valid && (state == LOAD);
  assign last_pix = (wr_col == CW'(IMAGE_WIDTH - 1)) && (wr_row == RW'(IMAGE_HEIGHT - 1));
  assign wr_addr  = AW'(int'(wr_brow) * IMAGE_WIDTH + int'(wr_col));

  assign issue   = (state == STREAM) && !issue_done && !skid_valid;
  assign hs      = o_valid_data_to_conv && i_conv_ready;
  // Skid full implies the read stage is full too, so an empty skid means one slice left.
  assign last_hs = hs && issue_done && !skid_valid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= LOAD;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      LOAD:    if (wr_en && last_pix) state_next = FULL;
      FULL:    if (i_read_valid)      state_next = STREAM;
      STREAM:  if (last_hs)           state_next = LOAD;
      default: state_next = LOAD;
    endcase
  end

  always_comb begin
    o_load_ready         = (state == LOAD);
    o_frame_ready        = (state == FULL);
    o_valid_data_to_conv = skid_valid || rd_valid;
    o_to_conv            = skid_valid ? skid_data : (rd_valid ? rot_data : '0);
    o_frame_done         = frame_done_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_col  <= '0;
      wr_row  <= '0;
      wr_bank <= '0;
      wr_brow <= '0;
    end else if (wr_en) begin
      if (wr_col == CW'(IMAGE_WIDTH - 1)) begin
        wr_col <= '0;
        if (wr_row == RW'(IMAGE_HEIGHT - 1)) begin
          wr_row  <= '0;
          wr_bank <= '0;
          wr_brow <= '0;
        end else begin
          wr_row <= wr_row + 1'b1;
          if (wr_bank == KW'(KERNEL_WIDTH - 1)) begin
            wr_bank <= '0;
            wr_brow <= wr_brow + 1'b1;
          end else begin
            wr_bank <= wr_bank + 1'b1;
          end
        end
      end else begin
        wr_col <= wr_col + 1'b1;
      end
    end
  end

  // Bank b holds the window row congruent to b; rows outside the frame read as zero.
  always_comb begin
    bank_ok = '0;
    for (int b = 0; b < KERNEL_WIDTH; b++) begin
      int br;
      int row;
      rd_addr[b] = '0;
      br  = int'(top_div) - 1 + ((b < int'(top_mod)) ? 1 : 0);
      row = br * KERNEL_WIDTH + b;
      bank_ok[b] = (br >= 0) && (row < IMAGE_HEIGHT);
      if (bank_ok[b]) rd_addr[b] = AW'(br * IMAGE_WIDTH + int'(rd_col));
    end
  end

  always_ff @(posedge clk) begin
    for (int b = 0; b < KERNEL_WIDTH; b++) begin
      if (wr_en && (wr_bank == KW'(b))) mem[b][wr_addr] <= i_data_to_mem;
      if (issue) bank_q[b] <= mem[b][rd_addr[b]];
    end
  end

  always_comb begin
    rot_data = '0;
    for (int k = 0; k < KERNEL_WIDTH; k++) begin
      logic [KW1-1:0] sum;
      logic [KW-1:0]  bi;
      sum = {1'b0, tmod_q} + KW1'(k);
      if (sum >= KW1'(KERNEL_WIDTH)) sum = sum - KW1'(KERNEL_WIDTH);
      bi = sum[KW-1:0];
      if (lane_ok_q[bi]) rot_data[k*RAM_WIDTH +: RAM_WIDTH] = bank_q[bi];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_col       <= '0;
      rd_step      <= '0;
      top_mod      <= KW'(TMOD0);
      top_div      <= DW'(TDIV0);
      issue_done   <= 1'b0;
      tmod_q       <= '0;
      lane_ok_q    <= '0;
      rd_valid     <= 1'b0;
      skid_valid   <= 1'b0;
      skid_data    <= '0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= last_hs;
      if (last_hs) begin
        rd_col     <= '0;
        rd_step    <= '0;
        top_mod    <= KW'(TMOD0);
        top_div    <= DW'(TDIV0);
        issue_done <= 1'b0;
      end else if (issue) begin
        if (rd_col == CW'(IMAGE_WIDTH - 1)) begin
          rd_col <= '0;
          if (rd_step == RW'(NUM_TOPS - 1)) begin
            issue_done <= 1'b1;
          end else begin
            rd_step <= rd_step + 1'b1;
            if (top_mod == KW'(KERNEL_WIDTH - 1)) begin
              top_mod <= '0;
              top_div <= top_div + 1'b1;
            end else begin
              top_mod <= top_mod + 1'b1;
            end
          end
        end else begin
          rd_col <= rd_col + 1'b1;
        end
      end

      if (issue) begin
        tmod_q    <= top_mod;
        lane_ok_q <= bank_ok;
      end

      if (issue)                  rd_valid <= 1'b1;
      else if (hs && !skid_valid) rd_valid <= 1'b0;

      // A stalled read-stage slice parks in the skid while the next read lands.
      if (skid_valid && hs) begin
        skid_valid <= 1'b0;
      end else if (!skid_valid && rd_valid && !i_conv_ready && issue) begin
        skid_valid <= 1'b1;
        skid_data  <= rot_data;
      end
    end
  end

endmodule

// File: tb/tb_frame_window_buffer.sv
// tb/tb_frame_window_buffer.sv - directed bench for frame_window_buffer at default parameters
module tb_frame_window_buffer;

  localparam int RW = 8;
  localparam int IW = 10;
  localparam int IH = 10;
  localparam int K  = 3;
`ifdef FRAME_WINDOW_ZERO_PAD_EN
  localparam int          PADR   = 1;
  localparam int          NUM    = 100;
  localparam logic [23:0] FIRST  = 24'h0A0000;
  localparam logic [23:0] LAST   = 24'h006359;
  localparam logic [23:0] HELD11 = 24'h150B01;
`else
  localparam int          PADR   = 0;
  localparam int          NUM    = 80;
  localparam logic [23:0] FIRST  = 24'h140A00;
  localparam logic [23:0] LAST   = 24'h63594F;
  localparam logic [23:0] HELD11 = 24'h1F150B;
`endif

  logic        clk;
  logic        reset;
  logic        i_load_valid;
  logic [7:0]  i_data_to_mem;
  logic        o_load_ready;
  logic        i_read_valid;
  logic        o_frame_ready;
  logic        o_valid_data_to_conv;
  logic        i_conv_ready;
  logic [23:0] o_to_conv;
  logic        o_frame_done;

  int errors = 0;
  int checks = 0;

  frame_window_buffer #(
    .RAM_WIDTH(RW), .IMAGE_WIDTH(IW), .IMAGE_HEIGHT(IH), .KERNEL_WIDTH(K)
  ) dut (
    .clk(clk), .reset(reset),
    .i_load_valid(i_load_valid), .i_data_to_mem(i_data_to_mem), .o_load_ready(o_load_ready),
    .i_read_valid(i_read_valid), .o_frame_ready(o_frame_ready),
    .o_valid_data_to_conv(o_valid_data_to_conv), .i_conv_ready(i_conv_ready),
    .o_to_conv(o_to_conv), .o_frame_done(o_frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pixel n holds value n; lane k of slice idx is row (top+k), zero outside the frame.
  function automatic logic [23:0] exp_slice(input int idx);
    logic [23:0] s;
    int t, c, row;
    s = '0;
    t = idx / IW - PADR;
    c = idx % IW;
    for (int k = 0; k < K; k++) begin
      row = t + k;
      if (row >= 0 && row < IH) s[k*8 +: 8] = 8'(row * IW + c);
    end
    return s;
  endfunction

  task automatic load_pixels(input int start, input int count);
    for (int i = 0; i < count; i++) begin
      i_load_valid  = 1'b1;
      i_data_to_mem = 8'(start + i);
      @(negedge clk);
    end
    i_load_valid = 1'b0;
  endtask

  task automatic start_stream();
    i_conv_ready = 1'b1;
    i_read_valid = 1'b1;
    @(negedge clk);
    i_read_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    i_load_valid = 1'b0; i_data_to_mem = '0; i_read_valid = 1'b0; i_conv_ready = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (o_frame_ready !== 1'b0 || o_valid_data_to_conv !== 1'b0 || o_frame_done !== 1'b0)
      begin errors++; $display("FAIL reset_flags: ready=%b valid=%b done=%b want 0 0 0", o_frame_ready, o_valid_data_to_conv, o_frame_done); end
    checks++;
    if (o_to_conv !== 24'h0) begin errors++; $display("FAIL reset_data: got %h want 000000", o_to_conv); end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (o_load_ready !== 1'b1) begin errors++; $display("FAIL reset_load_ready: got %b want 1", o_load_ready); end
  endtask

  task automatic test_read_during_load();
    load_pixels(0, 50);
    i_read_valid = 1'b1;
    @(negedge clk);
    i_read_valid = 1'b0;
    for (int c = 0; c < 6; c++) begin
      checks++;
      if (o_valid_data_to_conv !== 1'b0 || o_frame_ready !== 1'b0 || o_load_ready !== 1'b1)
        begin errors++; $display("FAIL read_in_load cyc%0d: valid=%b frame_ready=%b load_ready=%b want 0 0 1", c, o_valid_data_to_conv, o_frame_ready, o_load_ready); end
      @(negedge clk);
    end
  endtask

  task automatic test_load();
    load_pixels(50, 49);
    checks++;
    if (o_frame_ready !== 1'b0 || o_load_ready !== 1'b1)
      begin errors++; $display("FAIL load_99: frame_ready=%b load_ready=%b want 0 1", o_frame_ready, o_load_ready); end
    load_pixels(99, 1);
    checks++;
    if (o_frame_ready !== 1'b1 || o_load_ready !== 1'b0)
      begin errors++; $display("FAIL load_100: frame_ready=%b load_ready=%b want 1 0", o_frame_ready, o_load_ready); end
    for (int i = 0; i < 3; i++) begin
      i_load_valid = 1'b1; i_data_to_mem = 8'hEE;
      @(negedge clk);
    end
    i_load_valid = 1'b0;
    checks++;
    if (o_frame_ready !== 1'b1 || o_load_ready !== 1'b0)
      begin errors++; $display("FAIL load_extra: frame_ready=%b load_ready=%b want 1 0", o_frame_ready, o_load_ready); end
  endtask

  task automatic test_stream();
    int idx, done_cnt, post;
    logic [23:0] first, last;
    idx = 0; done_cnt = 0; post = 0; first = '0; last = '0;
    start_stream();
    checks++;
    if (o_valid_data_to_conv !== 1'b0) begin errors++; $display("FAIL latency_1: valid=%b want 0", o_valid_data_to_conv); end
    @(negedge clk);
    checks++;
    if (o_valid_data_to_conv !== 1'b1) begin errors++; $display("FAIL latency_2: valid=%b want 1", o_valid_data_to_conv); end
    for (int cyc = 0; cyc < 400 && post < 4; cyc++) begin
      if (o_frame_done === 1'b1) begin
        done_cnt++;
        checks++;
        if (idx != NUM || o_load_ready !== 1'b1)
          begin errors++; $display("FAIL stream_done: slices=%0d load_ready=%b want %0d 1", idx, o_load_ready, NUM); end
      end
      if (done_cnt > 0) post++;
      if (o_valid_data_to_conv === 1'b1) begin
        checks++;
        if (o_to_conv !== exp_slice(idx))
          begin errors++; $display("FAIL stream_slice %0d: got %h want %h", idx, o_to_conv, exp_slice(idx)); end
        if (idx == 0) first = o_to_conv;
        last = o_to_conv;
        idx++;
      end
      @(negedge clk);
    end
    checks++;
    if (first !== FIRST) begin errors++; $display("FAIL stream_first: got %h want %h", first, FIRST); end
    checks++;
    if (last !== LAST) begin errors++; $display("FAIL stream_last: got %h want %h", last, LAST); end
    checks++;
    if (idx != NUM) begin errors++; $display("FAIL stream_count: got %0d want %0d", idx, NUM); end
    checks++;
    if (done_cnt != 1) begin errors++; $display("FAIL stream_done_pulses: got %0d want 1", done_cnt); end
  endtask

  task automatic test_backpressure();
    int idx, done_cnt, post, s1, s2;
    logic [23:0] held;
    idx = 0; done_cnt = 0; post = 0; s1 = 0; s2 = 0; held = '0;
    load_pixels(0, 100);
    start_stream();
    for (int cyc = 0; cyc < 600 && post < 4; cyc++) begin
      if (o_frame_done === 1'b1) begin
        done_cnt++;
        checks++;
        if (idx != NUM) begin errors++; $display("FAIL bp_done: slices=%0d want %0d", idx, NUM); end
      end
      if (done_cnt > 0) post++;
      if (idx == 11 && s1 < 5 && (o_valid_data_to_conv === 1'b1 || s1 > 0)) begin
        i_conv_ready = 1'b0;
        if (s1 == 0) held = o_to_conv;
        checks++;
        if (o_valid_data_to_conv !== 1'b1 || o_to_conv !== exp_slice(11))
          begin errors++; $display("FAIL bp_hold cyc%0d: valid=%b data=%h want 1 %h", s1, o_valid_data_to_conv, o_to_conv, exp_slice(11)); end
        s1++;
      end else if (idx == 50 && s2 < 1 && o_valid_data_to_conv === 1'b1) begin
        i_conv_ready = 1'b0;
        checks++;
        if (o_to_conv !== exp_slice(50)) begin errors++; $display("FAIL bp_hold50: got %h want %h", o_to_conv, exp_slice(50)); end
        s2++;
      end else begin
        i_conv_ready = 1'b1;
        if (o_valid_data_to_conv === 1'b1) begin
          checks++;
          if (o_to_conv !== exp_slice(idx))
            begin errors++; $display("FAIL bp_slice %0d: got %h want %h", idx, o_to_conv, exp_slice(idx)); end
          idx++;
        end
      end
      @(negedge clk);
    end
    i_conv_ready = 1'b1;
    checks++;
    if (held !== HELD11) begin errors++; $display("FAIL bp_held_value: got %h want %h", held, HELD11); end
    checks++;
    if (idx != NUM || done_cnt != 1 || s1 != 5)
      begin errors++; $display("FAIL bp_count: slices=%0d done=%0d stalls=%0d want %0d 1 5", idx, done_cnt, s1, NUM); end
  endtask

  task automatic test_reset_mid_stream();
    int idx;
    idx = 0;
    load_pixels(0, 100);
    start_stream();
    for (int cyc = 0; cyc < 200; cyc++) begin
      if (o_valid_data_to_conv === 1'b1) begin
        if (idx == 40) break;
        idx++;
      end
      @(negedge clk);
    end
    checks++;
    if (idx != 40) begin errors++; $display("FAIL mid_reach40: got %0d want 40", idx); end
    reset = 1'b1;
    #1;
    checks++;
    if (o_frame_ready !== 1'b0 || o_valid_data_to_conv !== 1'b0 || o_frame_done !== 1'b0 || o_to_conv !== 24'h0)
      begin errors++; $display("FAIL mid_reset_outputs: fr=%b v=%b d=%b data=%h want 0 0 0 000000", o_frame_ready, o_valid_data_to_conv, o_frame_done, o_to_conv); end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (o_load_ready !== 1'b1 || o_frame_ready !== 1'b0)
      begin errors++; $display("FAIL mid_release: load_ready=%b frame_ready=%b want 1 0", o_load_ready, o_frame_ready); end
    load_pixels(0, 100);
    checks++;
    if (o_frame_ready !== 1'b1) begin errors++; $display("FAIL mid_reload: frame_ready=%b want 1", o_frame_ready); end
    start_stream();
    @(negedge clk);
    checks++;
    if (o_valid_data_to_conv !== 1'b1 || o_to_conv !== FIRST)
      begin errors++; $display("FAIL mid_restart_first: valid=%b data=%h want 1 %h", o_valid_data_to_conv, o_to_conv, FIRST); end
  endtask

  initial begin
    test_reset();
    test_read_during_load();
    test_load();
    test_stream();
    test_backpressure();
    test_reset_mid_stream();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
